// File: rtl/data_mem_responder.sv
// data_mem_responder
// Receiving end of the core's MemRead/MemWrite interface. A load or store is
// accepted in IDLE, its operands are captured, and it completes LATENCY cycles
// later with a one-cycle MemDone pulse (MemErr alongside for illegal requests).
// MemBusy stalls the pipeline while the request is outstanding. Byte, half and
// word accesses are little-endian with sign/zero extension chosen by Funct3.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous, active-high reset
//   MemRead  - load request
//   MemWrite - store request
//   Funct3   - access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   Addr     - byte address; word index is Addr[ADDR_W+1:2], upper bits alias
//   WrData   - store data, low bits used for B/H
//   RdData   - extended load result, held until the next load completes
//   MemBusy  - stall request (combinational)
//   MemDone  - one-cycle completion pulse
//   MemErr   - one-cycle error pulse, coincident with MemDone
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [31:0]       Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              MemBusy,
    output logic              MemDone,
    output logic              MemErr
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
    localparam logic       LAT_ONE = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Illegal combination of request type, size and alignment.
    function automatic logic req_error(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = lo[0];
            F3_W:    bad = (lo != 2'b00);
            F3_BU:   bad = wr;
            F3_HU:   bad = wr | lo[0];
            default: bad = 1'b1;
        endcase
        return (rd & wr) | bad;
    endfunction

    // Lanes touched by a store.
    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << lo;
            F3_H:    be = lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low store bits onto every lane so the enables pick the right one.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3)
            F3_B:    lanes = {4{wd[7:0]}};
            F3_H:    lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    // Select the addressed byte/half and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'd0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'd0, h};
            F3_W:    r = w;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [31:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              req_s;
    logic              op_rd_s, op_wr_s;
    logic [2:0]        op_f3_s;
    logic [ADDR_W+1:0] op_addr_s;
    logic [31:0]       op_wdata_s;
    logic              op_err_s;
    logic              finish_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic [3:0]        be_s;
    logic [31:0]       lanes_s;
    logic [31:0]       mem_rword_s;
    logic              unused_addr_s;

    assign unused_addr_s = ^Addr[31:ADDR_W+2];
    assign req_s         = MemRead | MemWrite;

    // Operand source: with LATENCY==1 the access finishes on the acceptance edge,
    // before the capture registers are loaded, so IDLE uses the live inputs.
    always_comb begin
        op_rd_s    = rd_q;
        op_wr_s    = wr_q;
        op_f3_s    = f3_q;
        op_addr_s  = addr_q;
        op_wdata_s = wdata_q;
        if (state_q == ST_IDLE) begin
            op_rd_s    = MemRead;
            op_wr_s    = MemWrite;
            op_f3_s    = Funct3;
            op_addr_s  = Addr[ADDR_W+1:0];
            op_wdata_s = WrData;
        end else begin
            op_rd_s    = rd_q;
        end
    end

    assign op_err_s    = req_error(op_rd_s, op_wr_s, op_f3_s, op_addr_s[1:0]);
    assign word_idx_s  = op_addr_s[ADDR_W+1:2];
    assign be_s        = byte_enables(op_f3_s, op_addr_s[1:0]);
    assign lanes_s     = store_lanes(op_f3_s, op_wdata_s);
    assign mem_rword_s = mem[word_idx_s];

    // The edge ending this cycle enters DONE: commit the store / latch the load.
    always_comb begin
        finish_s = 1'b0;
        if (state_q == ST_IDLE) begin
            finish_s = req_s & LAT_ONE;
        end else if (state_q == ST_WAIT) begin
            finish_s = (cnt_q == LAT_M1);
        end else begin
            finish_s = 1'b0;
        end
    end

    // A reset on the commit edge discards the pending store.
    assign mem_we_s = finish_s & op_wr_s & ~op_err_s & ~reset;

    // Stall: request present in IDLE, or still waiting.
    always_comb begin
        MemBusy = 1'b0;
        if (state_q == ST_IDLE) begin
            MemBusy = req_s;
        end else if (state_q == ST_WAIT) begin
            MemBusy = 1'b1;
        end else begin
            MemBusy = 1'b0;
        end
    end

    // Next-state, capture and output computation for the request FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    f3_d    = Funct3;
                    addr_d  = Addr[ADDR_W+1:0];
                    wdata_d = WrData;
                    if (LAT_ONE) begin
                        state_d = ST_DONE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_M1) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (finish_s) begin
            done_d = 1'b1;
            err_d  = op_err_s;
            if (op_rd_s) begin
                rdata_d = op_err_s ? 32'd0 : load_extract(op_f3_s, op_addr_s[1:0], mem_rword_s);
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            done_d = 1'b0;
        end
    end

    // FSM state, captured request and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Storage array with per-lane write enables; never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem[word_idx_s][8*i +: 8] <= lanes_s[8*i +: 8];
                end
            end
        end
    end

    assign RdData  = rdata_q;
    assign MemDone = done_q;
    assign MemErr  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 4) share the
// clock and reset. A behavioural model (word array + size/alignment rules)
// predicts busy/done/err timing and load results for directed and random ops.
module tb_data_mem_responder;

    localparam int ND = 3;

    logic        clk;
    logic        reset;
    logic        rd_s    [ND];
    logic        wr_s    [ND];
    logic [2:0]  f3_s    [ND];
    logic [31:0] addr_s  [ND];
    logic [31:0] wdata_s [ND];
    logic [31:0] rdata_s [ND];
    logic        busy_s  [ND];
    logic        done_s  [ND];
    logic        err_s   [ND];

    logic [31:0] model_mem [ND][512];
    logic [31:0] last_rd   [ND];
    int checks;
    int errors;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        data_mem_responder #(
            .DATA_W (32),
            .ADDR_W (9),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .MemRead (rd_s[g]),
            .MemWrite(wr_s[g]),
            .Funct3  (f3_s[g]),
            .Addr    (addr_s[g]),
            .WrData  (wdata_s[g]),
            .RdData  (rdata_s[g]),
            .MemBusy (busy_s[g]),
            .MemDone (done_s[g]),
            .MemErr  (err_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Error rules: both requests, unknown size, unsigned store, misalignment.
    function automatic bit ref_err(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a);
        int sz;
        sz = size_of(f3);
        if (rd && wr) return 1'b1;
        if (sz == 0) return 1'b1;
        if (wr && f3 >= 3'd4) return 1'b1;
        if ((int'(a[1:0]) % sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] size_mask(input int sz);
        logic [31:0] m;
        m = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        return m;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] m;
        int sh;
        m  = size_mask(size_of(f3));
        sh = 8 * int'(a[1:0]);
        return (old & ~(m << sh)) | ((wd & m) << sh);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [31:0] m;
        logic [31:0] v;
        int sz;
        sz = size_of(f3);
        m  = size_mask(sz);
        v  = (w >> (8 * int'(a[1:0]))) & m;
        if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~m;
        return v;
    endfunction

    // Issue one request on instance d and check every cycle until its MemDone.
    task automatic do_op(input int d, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input string name);
        int lat;
        int idx;
        bit e;
        logic [31:0] exp_rd;
        lat = lat_of(d);
        idx = int'((a >> 2) % 512);
        e   = ref_err(rd, wr, f3, a);
        exp_rd = rd ? (e ? 32'd0 : ref_load(model_mem[d][idx], f3, a)) : last_rd[d];
        @(posedge clk);
        #1;
        rd_s[d] = rd; wr_s[d] = wr; f3_s[d] = f3; addr_s[d] = a; wdata_s[d] = wd;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            checks++;
            if (busy_s[d] !== 1'b1 || done_s[d] !== 1'b0 || err_s[d] !== 1'b0 ||
                rdata_s[d] !== last_rd[d]) begin
                errors++;
                $display("FAIL %s busy d%0d cyc%0d: busy=%b done=%b err=%b rdata=%h, required 1 0 0 %h",
                         name, d, k, busy_s[d], done_s[d], err_s[d], rdata_s[d], last_rd[d]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy_s[d] !== 1'b0 || done_s[d] !== 1'b1 || err_s[d] !== e || rdata_s[d] !== exp_rd) begin
            errors++;
            $display("FAIL %s done d%0d: busy=%b done=%b err=%b rdata=%h, required 0 1 %b %h",
                     name, d, busy_s[d], done_s[d], err_s[d], rdata_s[d], e, exp_rd);
        end
        if (wr && !e) model_mem[d][idx] = ref_store(model_mem[d][idx], f3, a, wd);
        last_rd[d] = exp_rd;
        rd_s[d] = 1'b0; wr_s[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < ND; d++) begin
            rd_s[d] = 1'b0; wr_s[d] = 1'b0; f3_s[d] = 3'd0; addr_s[d] = 32'd0; wdata_s[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            last_rd[d] = 32'd0;
            checks++;
            if (rdata_s[d] !== 32'd0 || busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 || err_s[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state d%0d: rdata=%h busy=%b done=%b err=%b, required all 0",
                         d, rdata_s[d], busy_s[d], done_s[d], err_s[d]);
            end
        end
    endtask

    task automatic test_fill();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 512; i++) begin
                do_op(d, 1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom, "fill");
            end
        end
    endtask

    task automatic test_store_load();
        do_op(0, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw_10");
        do_op(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, "lw_10");
        checks++;
        if (rdata_s[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_10_value: got %h, required deadbeef", rdata_s[0]);
        end
    endtask

    task automatic test_extension();
        logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] as   [4] = '{32'h20, 32'h20, 32'h22, 32'h20};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00001234, 32'h00005680};
        do_op(0, 1'b0, 1'b1, 3'd2, 32'h20, 32'h12345680, "sw_20");
        for (int i = 0; i < 4; i++) begin
            do_op(0, 1'b1, 1'b0, f3s[i], as[i], 32'd0, "ext_load");
            checks++;
            if (rdata_s[0] !== exps[i]) begin
                errors++;
                $display("FAIL ext_value%0d: got %h, required %h", i, rdata_s[0], exps[i]);
            end
        end
    endtask

    task automatic test_merge();
        do_op(0, 1'b0, 1'b1, 3'd2, 32'h30, 32'hAAAAAAAA, "sw_30");
        do_op(0, 1'b0, 1'b1, 3'd1, 32'h32, 32'h0000BEEF, "sh_32");
        do_op(0, 1'b0, 1'b1, 3'd0, 32'h30, 32'h00000011, "sb_30");
        do_op(0, 1'b1, 1'b0, 3'd2, 32'h30, 32'd0, "lw_30");
        checks++;
        if (rdata_s[0] !== 32'hBEEFAA11) begin
            errors++;
            $display("FAIL merge_value: got %h, required beefaa11", rdata_s[0]);
        end
    endtask

    task automatic test_errors();
        do_op(0, 1'b0, 1'b1, 3'd2, 32'h04, 32'hCAFEF00D, "sw_04");
        do_op(0, 1'b1, 1'b0, 3'd2, 32'h06, 32'd0, "lw_misaligned");
        do_op(0, 1'b1, 1'b1, 3'd2, 32'h04, 32'h11111111, "rd_and_wr");
        do_op(0, 1'b0, 1'b1, 3'd4, 32'h04, 32'h22222222, "sbu_store");
        do_op(0, 1'b0, 1'b1, 3'd1, 32'h05, 32'h33333333, "sh_misaligned");
        do_op(0, 1'b1, 1'b0, 3'd3, 32'h04, 32'd0, "f3_reserved");
        do_op(0, 1'b1, 1'b0, 3'd5, 32'h07, 32'd0, "lhu_misaligned");
        do_op(0, 1'b1, 1'b0, 3'd2, 32'h04, 32'd0, "lw_04");
        checks++;
        if (rdata_s[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL err_no_write: got %h, required cafef00d", rdata_s[0]);
        end
    endtask

    // Store accepted, then reset k cycles later while it is still in flight.
    task automatic test_reset_mid(input int d, input int k);
        do_op(d, 1'b0, 1'b1, 3'd2, 32'h40, 32'h13572468, "sw_40_prior");
        @(posedge clk);
        #1;
        rd_s[d] = 1'b0; wr_s[d] = 1'b1; f3_s[d] = 3'd2; addr_s[d] = 32'h40; wdata_s[d] = 32'h55;
        repeat (k) @(posedge clk);
        #1;
        reset = 1'b1;
        wr_s[d] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (done_s[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_done d%0d: done=%b, required 0", d, done_s[d]);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rdata_s[d] !== 32'd0 || busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 || err_s[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_outputs d%0d: rdata=%h busy=%b done=%b err=%b, required all 0",
                         d, rdata_s[d], busy_s[d], done_s[d], err_s[d]);
            end
        end
        for (int j = 0; j < ND; j++) last_rd[j] = 32'd0;
        do_op(d, 1'b1, 1'b0, 3'd2, 32'h40, 32'd0, "lw_40_after_reset");
        checks++;
        if (rdata_s[d] !== 32'h13572468) begin
            errors++;
            $display("FAIL reset_mid_no_write d%0d: got %h, required 13572468", d, rdata_s[d]);
        end
    endtask

    task automatic test_back_to_back();
        do_op(1, 1'b0, 1'b1, 3'd2, 32'h800, 32'h0BADF00D, "sw_alias");
        do_op(1, 1'b1, 1'b0, 3'd2, 32'h000, 32'd0, "lw_0_b2b");
        checks++;
        if (rdata_s[1] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL alias_value: got %h, required 0badf00d", rdata_s[1]);
        end
        do_op(1, 1'b1, 1'b0, 3'd2, 32'h010, 32'd0, "lw_b2b_second");
        // MemDone must drop in the idle cycle after a completion.
        @(negedge clk);
        checks++;
        if (done_s[1] !== 1'b0 || busy_s[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: done=%b busy=%b, required 0 0", done_s[1], busy_s[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int d;
            bit rd;
            bit wr;
            logic [2:0] f3;
            logic [31:0] a;
            int sz;
            d  = int'($urandom_range(0, ND - 1));
            rd = $urandom_range(0, 1) == 1;
            wr = !rd;
            if ($urandom_range(0, 15) == 0) begin
                rd = 1'b1; wr = 1'b1;
            end
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = wr ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 1) * 4) + $urandom_range(0, 1));
            a  = $urandom;
            sz = size_of(f3);
            if (sz != 0 && $urandom_range(0, 4) != 0) a = a & ~32'(sz - 1);
            do_op(d, rd, wr, f3, a, $urandom, "random");
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                checks++;
                if (done_s[d] !== 1'b0 || busy_s[d] !== 1'b0 || rdata_s[d] !== last_rd[d]) begin
                    errors++;
                    $display("FAIL random_idle d%0d: done=%b busy=%b rdata=%h, required 0 0 %h",
                             d, done_s[d], busy_s[d], rdata_s[d], last_rd[d]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_store_load();
        test_extension();
        test_merge();
        test_errors();
        test_reset_mid(0, 1);
        test_reset_mid(2, 3);
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
